// File: rtl/sram_bist_pkg.sv
// Shared types and March C- element tables for the SRAM BIST sequencer.
// Table bit index = element number (M0 in bit 0).
package sram_bist_pkg;

    typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} march_elem_e;
    typedef enum logic {OP_RD, OP_WR} op_e;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    localparam march_elem_e MARCH_LAST_ELEM = M5;

    localparam logic [5:0] ELEM_DOWN   = 6'b011000;
    localparam logic [5:0] ELEM_HAS_RD = 6'b111110;
    localparam logic [5:0] ELEM_HAS_WR = 6'b011111;
    localparam logic [5:0] ELEM_RD_VAL = 6'b010100;
    localparam logic [5:0] ELEM_WR_VAL = 6'b001010;

    function automatic march_elem_e next_elem(input march_elem_e e);
        return (e == MARCH_LAST_ELEM) ? e : march_elem_e'(e + 3'd1);
    endfunction

endpackage

// File: rtl/sram_bist_cmp.sv
// Read-compare stage: one-cycle pipelined expected data, sticky fail, saturating count.
// First-miscompare diagnostics are built only when BIST_DIAG_EN is defined.
module sram_bist_cmp
    import sram_bist_pkg::*;
#(
    parameter int unsigned P_DATA_WIDTH = 64,
    parameter int unsigned P_ADDR_WIDTH = 11
)(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clr_i,
    input  logic                    rd_valid_i,
    input  logic [P_DATA_WIDTH-1:0] exp_i,
    input  logic [P_ADDR_WIDTH-1:0] addr_i,
    input  march_elem_e             elem_i,
    input  logic [P_DATA_WIDTH-1:0] dout_i,
    output logic                    fail_o,
    output logic [15:0]             fail_cnt_o,
    output logic [P_ADDR_WIDTH-1:0] first_fail_addr_o,
    output logic [2:0]              first_fail_elem_o,
    output logic [P_DATA_WIDTH-1:0] first_fail_syn_o
);

    logic                    valid_q;
    logic [P_DATA_WIDTH-1:0] exp_q;
    logic                    fail_q;
    logic [15:0]             cnt_q;
    logic                    miscmp;

    assign miscmp = valid_q && (dout_i != exp_q);

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            valid_q <= 1'b0;
            exp_q   <= '0;
            fail_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= rd_valid_i;
            if (rd_valid_i) exp_q <= exp_i;
            if (miscmp) begin
                fail_q <= 1'b1;
                if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign fail_o     = fail_q;
    assign fail_cnt_o = cnt_q;

`ifdef BIST_DIAG_EN
    logic [P_ADDR_WIDTH-1:0] addr_q, ff_addr_q;
    logic [2:0]              elem_q, ff_elem_q;
    logic [P_DATA_WIDTH-1:0] ff_syn_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            addr_q    <= '0;
            elem_q    <= '0;
            ff_addr_q <= '0;
            ff_elem_q <= '0;
            ff_syn_q  <= '0;
        end else begin
            if (rd_valid_i) begin
                addr_q <= addr_i;
                elem_q <= elem_i;
            end
            // fail_q still low means this is the first miscompare of the run
            if (miscmp && !fail_q) begin
                ff_addr_q <= addr_q;
                ff_elem_q <= elem_q;
                ff_syn_q  <= dout_i ^ exp_q;
            end
        end
    end

    assign first_fail_addr_o = ff_addr_q;
    assign first_fail_elem_o = ff_elem_q;
    assign first_fail_syn_o  = ff_syn_q;
`else
    logic diag_unused;
    assign diag_unused       = ^{addr_i, elem_i};
    assign first_fail_addr_o = '0;
    assign first_fail_elem_o = '0;
    assign first_fail_syn_o  = '0;
`endif

endmodule

// File: rtl/sram_bist_march_ctrl.sv
// March C- BIST sequencer driving the macro A_BIST_* port group; one access per cycle.
// Optional first-fail diagnostics in sram_bist_cmp under macro BIST_DIAG_EN.
module sram_bist_march_ctrl
    import sram_bist_pkg::*;
#(
    parameter int unsigned           P_DATA_WIDTH = 64,
    parameter int unsigned           P_ADDR_WIDTH = 11,
    parameter int unsigned           DEPTH        = 2048,
    parameter logic [P_DATA_WIDTH-1:0] P_BG       = '0
)(
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    fail,
    output logic [15:0]             fail_cnt,
    output logic [P_ADDR_WIDTH-1:0] first_fail_addr,
    output logic [2:0]              first_fail_elem,
    output logic [P_DATA_WIDTH-1:0] first_fail_syn,
    output logic                    A_BIST_EN,
    output logic                    A_BIST_MEN,
    output logic                    A_BIST_WEN,
    output logic                    A_BIST_REN,
    output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
    output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
    output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
    input  logic [P_DATA_WIDTH-1:0] A_DOUT
);

    localparam logic [P_ADDR_WIDTH-1:0] LAST_ADDR = P_ADDR_WIDTH'(DEPTH - 1);

    state_e                  state_q, state_d;
    march_elem_e             elem_q, elem_d, elem_nx;
    logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                    phase_q, phase_d;

    logic accept, running, down, addr_end, op_done, elem_end, last_op;
    op_e  cur_op;

    assign accept   = start && (state_q == IDLE || state_q == DONE);
    assign running  = (state_q == RUN);
    assign down     = ELEM_DOWN[elem_q];
    assign cur_op   = (ELEM_HAS_RD[elem_q] && !phase_q) ? OP_RD : OP_WR;
    // the address is finished after its write, or after the read in read-only elements
    assign op_done  = (cur_op == OP_WR) || !ELEM_HAS_WR[elem_q];
    assign addr_end = down ? (addr_q == '0) : (addr_q == LAST_ADDR);
    assign elem_end = op_done && addr_end;
    assign last_op  = running && elem_end && (elem_q == MARCH_LAST_ELEM);
    assign elem_nx  = next_elem(elem_q);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            elem_q  <= M0;
            addr_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            addr_q  <= addr_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last_op) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    if (accept) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        elem_d  = elem_q;
        addr_d  = addr_q;
        phase_d = phase_q;
        if (accept) begin
            elem_d  = M0;
            addr_d  = '0;
            phase_d = 1'b0;
        end else if (running) begin
            if (!op_done) begin
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                if (elem_end) begin
                    elem_d = elem_nx;
                    addr_d = ELEM_DOWN[elem_nx] ? LAST_ADDR : '0;
                end else begin
                    addr_d = down ? addr_q - 1'b1 : addr_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        busy        = (state_q == RUN) || (state_q == DRAIN);
        done        = (state_q == DONE);
        A_BIST_EN   = busy;
        A_BIST_MEN  = running;
        A_BIST_REN  = running && (cur_op == OP_RD);
        A_BIST_WEN  = running && (cur_op == OP_WR);
        A_BIST_ADDR = running ? addr_q : '0;
        A_BIST_BM   = A_BIST_WEN ? '1 : '0;
        A_BIST_DIN  = '0;
        if (A_BIST_WEN) A_BIST_DIN = ELEM_WR_VAL[elem_q] ? ~P_BG : P_BG;
    end

    sram_bist_cmp #(
        .P_DATA_WIDTH (P_DATA_WIDTH),
        .P_ADDR_WIDTH (P_ADDR_WIDTH)
    ) u_cmp (
        .clk_i             (CLK),
        .rst_i             (RST),
        .clr_i             (accept),
        .rd_valid_i        (A_BIST_REN),
        .exp_i             (ELEM_RD_VAL[elem_q] ? ~P_BG : P_BG),
        .addr_i            (addr_q),
        .elem_i            (elem_q),
        .dout_i            (A_DOUT),
        .fail_o            (fail),
        .fail_cnt_o        (fail_cnt),
        .first_fail_addr_o (first_fail_addr),
        .first_fail_elem_o (first_fail_elem),
        .first_fail_syn_o  (first_fail_syn)
    );

endmodule
